decode_multi: RTL and testbench
===============================

Name: decode_multi

Overview:
- Parametrised, WIDTH-lane successor to the single-lane decode stage.
- Sits between fetch and rename/issue.
- Each cycle it takes a bundle of up to WIDTH fetched instructions, classifies each by execution unit and operand dependancy, and registers the decoded bundle behind a valid/ready handshake.
- Serialises control flow: accepts lanes only up to and including the first UNIT_FLOW instruction, tells fetch how many lanes it consumed, then blocks until the flow instruction resolves, followed by a programmable hold-off.

Parameters:
- WIDTH, 2, number of decode lanes (1..8).
- HOLDOFF, 2, cycles input stays blocked after flow release (0..15).
- CNT_W, $clog2(WIDTH+1), width of accept count (derived, not overridable).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- jump  in  1  redirect from flow unit: flush decode, release flow wait.
- flow_done  in  1  flow instruction resolved without redirect: release flow wait.
- instr_i  in  WIDTH x INSTRUCTION_FECHED  fetched bundle; lane 0 is oldest.
- valid_i  in  WIDTH  per-lane valid; contiguous from lane 0 (fetch guarantees this).
- ready_i  out  1  decode can accept a bundle this cycle.
- accept_o  out  CNT_W  lanes consumed this cycle (0..WIDTH); fetch re-presents the rest next cycle.
- instr_o  out  WIDTH x INSTRUCTION_DECODED  decoded bundle (unit, dependancy, instruction, pc, pc_4).
- valid_o  out  WIDTH  per-lane valid of instr_o.
- ready_o  in  1  downstream accepts the whole bundle.

Behaviour:
- Lane decode (combinational), same opcode map as the single-lane stage:
  - LUI, AUIPC -> ALU_INT/NO. ALUI -> ALU_INT/RS1. ALU -> ALU_INT/RS2.
  - JAL -> FLOW/NO. JALR -> FLOW/RS1. BRANCH -> FLOW/RS2.
  - LOAD -> LOAD_STORE/RS1. STORE -> LOAD_STORE/RS2.
  - FENCE -> NOT_IMPLEMENTED/NO. PRIVI -> NOT_IMPLEMENTED/RS1. Other opcodes -> NOT_IMPLEMENTED/NO.
- States: RUN, WAIT_FLOW, HOLD. Reset -> RUN, hold counter 0, valid_o all 0, instr_o don't-care.
- out_busy = |valid_o & !ready_o.
- ready_i = (state==RUN) & !out_busy & !jump.
- Cut point k:
  - k = index of the lowest valid lane whose unit==UNIT_FLOW.
  - If no such lane, k = index of the last valid lane.
  - accept_o = ready_i ? k+1 : 0.
  - accept_o = 0 when valid_i[0]=0.
- Transfer when ready_i & valid_i[0]:
  - Next cycle, instr_o gets lanes 0..k and valid_o = valid_i masked to lanes 0..k; lanes >k are cleared.
  - Latency is 1 cycle.
  - If a FLOW lane was taken, state -> WAIT_FLOW.
- No transfer and !out_busy: valid_o <= 0. While out_busy, instr_o/valid_o hold stable.
- WAIT_FLOW:
  - On jump or flow_done: state -> HOLD with counter = HOLDOFF, or -> RUN directly if HOLDOFF=0.
  - Release in the same cycle as the FLOW bundle is issued is legal; release takes effect from the next cycle.
- HOLD: counter decrements each cycle; at 1 -> RUN. ready_i = 0 throughout.
- jump (highest priority, any state):
  - valid_o <= 0 next cycle regardless of ready_o.
  - No transfer that cycle (ready_i = 0).
  - State -> HOLD/RUN as for release. A jump in HOLD restarts the counter.
- Simultaneous jump and flow_done: treat as jump.
- flow_done outside WAIT_FLOW is ignored.
- Reset mid-bundle: outputs clear next edge, no partial state survives.

Decomposition:
- Shared package: OPCODE_UNIT, OPCODE_DEPENDANCY, opcode constants, INSTRUCTION_FECHED, INSTRUCTION_DECODED, plus a decode-state enum DECODE_STATE {RUN, WAIT_FLOW, HOLD}.
- Sub-module decode_lane: purely combinational opcode -> {unit, dependancy}, instantiated WIDTH times via generate.
- decode_multi contains the cut-point priority logic, FSM, hold counter and output register.

Test Plan:
- WIDTH=2, bundle {ADDI, LW}, valid_i=11, ready_o=1 -> accept_o=2; next cycle valid_o=11, units {ALU_INT, LOAD_STORE}, deps {RS1, RS1}.
- Bundle {BEQ, ADD}, valid_i=11 -> accept_o=1, valid_o=01 next cycle, ready_i=0. flow_done pulse -> ready_i stays 0 for exactly 2 cycles (HOLDOFF=2), then 1.
- Bundle {JAL, x} in RUN; jump asserted 3 cycles later -> valid_o cleared, ready_i returns after HOLDOFF cycles. Bundle presented during HOLD -> accept_o=0.
- ready_o=0 for 4 cycles with valid_o=11 -> instr_o/valid_o stable, ready_i=0, accept_o=0. ready_o=1 -> new bundle accepted the same cycle.
- jump while out_busy with ready_o=0 -> valid_o=00 next cycle, nothing issued.
- Opcode 7'b1111111 in lane 0 -> unit UNIT_NOT_IMPLEMENTED, dep DEPENDANCY_NO, no flow wait. Reset asserted in WAIT_FLOW -> RUN, valid_o=0 next cycle.

Source files
------------

// File: rtl/decode_multi_pkg.sv
// Shared types for the multi-lane decode stage: unit/dependency classes, opcode map,
// fetched/decoded instruction records and the decode FSM state.
package decode_multi_pkg;

   typedef enum logic [1:0] {
      UNIT_ALU_INT,
      UNIT_LOAD_STORE,
      UNIT_FLOW,
      UNIT_NOT_IMPLEMENTED
   } OPCODE_UNIT;

   typedef enum logic [1:0] {
      DEPENDANCY_NO,
      DEPENDANCY_RS1,
      DEPENDANCY_RS2
   } OPCODE_DEPENDANCY;

   typedef enum logic [1:0] {
      RUN,
      WAIT_FLOW,
      HOLD
   } DECODE_STATE;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_ALUI   = 7'b0010011;
   localparam logic [6:0] OP_ALU    = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_PRIVI  = 7'b1110011;

   typedef struct packed {
      logic [31:0] instruction;
      logic [31:0] pc;
   } INSTRUCTION_FECHED;

   typedef struct packed {
      OPCODE_UNIT       unit;
      OPCODE_DEPENDANCY dependancy;
      logic [31:0]      instruction;
      logic [31:0]      pc;
      logic [31:0]      pc_4;
   } INSTRUCTION_DECODED;

   function automatic logic [6:0] opcode_of(input logic [31:0] instr);
      return instr[6:0];
   endfunction

endpackage

// File: rtl/decode_lane.sv
// Single-lane opcode classifier: maps a 7-bit opcode to execution unit and
// source-operand dependency. Purely combinational.
module decode_lane
   import decode_multi_pkg::*;
(
   input  logic [6:0]       opcode_i,
   output OPCODE_UNIT       unit_o,
   output OPCODE_DEPENDANCY dep_o
);

   always_comb begin
      unit_o = UNIT_NOT_IMPLEMENTED;
      dep_o  = DEPENDANCY_NO;
      case (opcode_i)
         OP_LUI, OP_AUIPC: begin unit_o = UNIT_ALU_INT;    dep_o = DEPENDANCY_NO;  end
         OP_ALUI:          begin unit_o = UNIT_ALU_INT;    dep_o = DEPENDANCY_RS1; end
         OP_ALU:           begin unit_o = UNIT_ALU_INT;    dep_o = DEPENDANCY_RS2; end
         OP_JAL:           begin unit_o = UNIT_FLOW;       dep_o = DEPENDANCY_NO;  end
         OP_JALR:          begin unit_o = UNIT_FLOW;       dep_o = DEPENDANCY_RS1; end
         OP_BRANCH:        begin unit_o = UNIT_FLOW;       dep_o = DEPENDANCY_RS2; end
         OP_LOAD:          begin unit_o = UNIT_LOAD_STORE; dep_o = DEPENDANCY_RS1; end
         OP_STORE:         begin unit_o = UNIT_LOAD_STORE; dep_o = DEPENDANCY_RS2; end
         OP_FENCE:         begin unit_o = UNIT_NOT_IMPLEMENTED; dep_o = DEPENDANCY_NO;  end
         OP_PRIVI:         begin unit_o = UNIT_NOT_IMPLEMENTED; dep_o = DEPENDANCY_RS1; end
         default:          begin unit_o = UNIT_NOT_IMPLEMENTED; dep_o = DEPENDANCY_NO;  end
      endcase
   end

endmodule

// File: rtl/decode_multi.sv
// WIDTH-lane decode stage: classifies a fetched bundle, cuts it after the first
// flow instruction, registers it behind valid/ready and stalls until flow resolves.
module decode_multi
   import decode_multi_pkg::*;
#(
   parameter int unsigned WIDTH   = 2,
   parameter int unsigned HOLDOFF = 2
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               jump,
   input  logic                               flow_done,
   input  INSTRUCTION_FECHED  [WIDTH-1:0]     instr_i,
   input  logic               [WIDTH-1:0]     valid_i,
   output logic                               ready_i,
   output logic [$clog2(WIDTH+1)-1:0]         accept_o,
   output INSTRUCTION_DECODED [WIDTH-1:0]     instr_o,
   output logic               [WIDTH-1:0]     valid_o,
   input  logic                               ready_o
);

   localparam int unsigned CNT_W = $clog2(WIDTH+1);

   OPCODE_UNIT         lane_unit [WIDTH];
   OPCODE_DEPENDANCY   lane_dep  [WIDTH];

   DECODE_STATE        state_q, state_d, rel_state;
   logic [3:0]         hold_q, hold_d;
   logic [WIDTH-1:0]   valid_q, valid_d;
   INSTRUCTION_DECODED [WIDTH-1:0] instr_q, instr_d;

   logic               out_busy, take, cut_flow;
   logic [CNT_W-1:0]   cut_k;

   for (genvar g = 0; g < WIDTH; g++) begin : g_lane
      decode_lane u_lane (
         .opcode_i (opcode_of(instr_i[g].instruction)),
         .unit_o   (lane_unit[g]),
         .dep_o    (lane_dep[g])
      );
   end

   // Cut point: first valid flow lane, else the last valid lane (valid_i is contiguous).
   always_comb begin
      cut_k    = '0;
      cut_flow = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (valid_i[i] && !cut_flow) begin
            cut_k    = CNT_W'(i);
            cut_flow = (lane_unit[i] == UNIT_FLOW);
         end
      end
   end

   assign out_busy  = (|valid_q) & ~ready_o;
   assign ready_i   = (state_q == RUN) & ~out_busy & ~jump;
   assign take      = ready_i & valid_i[0];
   assign accept_o  = take ? cut_k + CNT_W'(1) : '0;
   assign rel_state = (HOLDOFF == 0) ? RUN : HOLD;

   always_comb begin
      valid_d = valid_q;
      instr_d = instr_q;
      if (jump) begin
         valid_d = '0;
      end else if (take) begin
         for (int i = 0; i < WIDTH; i++) begin
            valid_d[i] = valid_i[i] && (CNT_W'(i) <= cut_k);
            if (valid_d[i]) begin
               instr_d[i].unit        = lane_unit[i];
               instr_d[i].dependancy  = lane_dep[i];
               instr_d[i].instruction = instr_i[i].instruction;
               instr_d[i].pc          = instr_i[i].pc;
               instr_d[i].pc_4        = instr_i[i].pc + 32'd4;
            end else begin
               instr_d[i] = '0;
            end
         end
      end else if (!out_busy) begin
         valid_d = '0;
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      if (jump) begin
         state_d = rel_state;
         hold_d  = 4'(HOLDOFF);
      end else begin
         case (state_q)
            RUN: begin
               if (take && cut_flow) state_d = WAIT_FLOW;
            end
            WAIT_FLOW: begin
               if (flow_done) begin
                  state_d = rel_state;
                  hold_d  = 4'(HOLDOFF);
               end
            end
            HOLD: begin
               if (hold_q <= 4'd1) begin
                  state_d = RUN;
                  hold_d  = '0;
               end else begin
                  hold_d = hold_q - 4'd1;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         hold_q  <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         valid_q <= valid_d;
      end
      instr_q <= instr_d;
   end

   assign valid_o = valid_q;
   assign instr_o = instr_q;

endmodule

// File: tb/tb_decode_multi.sv
// Self-checking bench for decode_multi (WIDTH=2, HOLDOFF=2) with a scoreboard of
// expected decoded bundles built from an independent opcode model.
module tb_decode_multi;
   import decode_multi_pkg::*;

   localparam int unsigned W  = 2;
   localparam int unsigned HO = 2;

   logic clk = 1'b0;
   logic reset, jump, flow_done, ready_o, ready_i;
   INSTRUCTION_FECHED  [W-1:0] instr_i;
   INSTRUCTION_DECODED [W-1:0] instr_o;
   logic [W-1:0] valid_i, valid_o;
   logic [1:0]   accept_o;

   typedef struct packed {
      logic [W-1:0]               valid;
      INSTRUCTION_DECODED [W-1:0] lanes;
   } sb_t;

   sb_t         sb_q[$];
   sb_t         last_exp;
   int          total = 0;
   int          bad   = 0;
   logic [31:0] pc_base = 32'h0000_1000;

   always #5 clk = ~clk;

   decode_multi #(.WIDTH(W), .HOLDOFF(HO)) dut (
      .clk       (clk),
      .reset     (reset),
      .jump      (jump),
      .flow_done (flow_done),
      .instr_i   (instr_i),
      .valid_i   (valid_i),
      .ready_i   (ready_i),
      .accept_o  (accept_o),
      .instr_o   (instr_o),
      .valid_o   (valid_o),
      .ready_o   (ready_o)
   );

   initial begin
      #200000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   function automatic OPCODE_UNIT m_unit(input logic [6:0] op);
      case (op)
         7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011: return UNIT_ALU_INT;
         7'b1101111, 7'b1100111, 7'b1100011:             return UNIT_FLOW;
         7'b0000011, 7'b0100011:                         return UNIT_LOAD_STORE;
         default:                                        return UNIT_NOT_IMPLEMENTED;
      endcase
   endfunction

   function automatic OPCODE_DEPENDANCY m_dep(input logic [6:0] op);
      case (op)
         7'b0010011, 7'b1100111, 7'b0000011, 7'b1110011: return DEPENDANCY_RS1;
         7'b0110011, 7'b1100011, 7'b0100011:             return DEPENDANCY_RS2;
         default:                                        return DEPENDANCY_NO;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives a bundle, checks handshake, scoreboards and checks the registered result.
   task automatic present(input logic [6:0] op0, input logic [6:0] op1, input logic [W-1:0] v,
                          input logic exp_rdy, input string name);
      logic [6:0]  ops [W];
      logic [31:0] r;
      int          k;
      logic        flow;
      logic [1:0]  exp_acc;
      sb_t         e;
      ops[0] = op0;
      ops[1] = op1;
      for (int i = 0; i < W; i++) begin
         r = $urandom();
         instr_i[i].instruction = {r[31:7], ops[i]};
         instr_i[i].pc          = pc_base + 32'(4 * i);
      end
      valid_i = v;
      k = 0;
      flow = 1'b0;
      for (int i = 0; i < W; i++) begin
         if (v[i] && !flow) begin
            k    = i;
            flow = (m_unit(ops[i]) == UNIT_FLOW);
         end
      end
      exp_acc = (exp_rdy && v[0]) ? 2'(k + 1) : 2'd0;
      #2;
      total++;
      if (ready_i !== exp_rdy) begin
         bad++;
         $display("FAIL %s ready_i got=%b want=%b", name, ready_i, exp_rdy);
      end
      total++;
      if (accept_o !== exp_acc) begin
         bad++;
         $display("FAIL %s accept_o got=%0d want=%0d", name, accept_o, exp_acc);
      end
      if (exp_acc != 2'd0) begin
         e = '0;
         for (int i = 0; i < W; i++) begin
            e.valid[i] = v[i] && (i <= k);
            if (e.valid[i]) begin
               e.lanes[i].unit        = m_unit(ops[i]);
               e.lanes[i].dependancy  = m_dep(ops[i]);
               e.lanes[i].instruction = instr_i[i].instruction;
               e.lanes[i].pc          = instr_i[i].pc;
               e.lanes[i].pc_4        = instr_i[i].pc + 32'd4;
            end
         end
         sb_q.push_back(e);
         pc_base = pc_base + 32'(4 * (k + 1));
      end
      step();
      if (exp_acc != 2'd0) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s scoreboard empty got=0 want=1", name);
         end else begin
            e = sb_q.pop_front();
            last_exp = e;
            total++;
            if (valid_o !== e.valid) begin
               bad++;
               $display("FAIL %s valid_o got=%b want=%b", name, valid_o, e.valid);
            end
            for (int i = 0; i < W; i++) begin
               if (e.valid[i]) begin
                  total++;
                  if (instr_o[i] !== e.lanes[i]) begin
                     bad++;
                     $display("FAIL %s lane%0d got=%h want=%h", name, i, instr_o[i], e.lanes[i]);
                  end
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
      total++;
      if (valid_o !== 2'b00) begin
         bad++;
         $display("FAIL reset_valid got=%b want=00", valid_o);
      end
      total++;
      if (ready_i !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready got=%b want=1", ready_i);
      end
      total++;
      if (accept_o !== 2'd0) begin
         bad++;
         $display("FAIL reset_accept got=%0d want=0", accept_o);
      end
   endtask

   task automatic test_alu_load();
      present(7'b0010011, 7'b0000011, 2'b11, 1'b1, "addi_lw");
      present(7'b0110011, 7'b0110011, 2'b01, 1'b1, "single_lane");
      valid_i = 2'b00;
      step();
      total++;
      if (valid_o !== 2'b00) begin
         bad++;
         $display("FAIL idle_clear got=%b want=00", valid_o);
      end
   endtask

   task automatic test_flow_holdoff();
      present(7'b1100011, 7'b0110011, 2'b11, 1'b1, "beq_add");
      present(7'b0110011, 7'b0110011, 2'b11, 1'b0, "wait_flow_block");
      valid_i   = 2'b00;
      flow_done = 1'b1;
      step();
      flow_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (ready_i !== (i == 2)) begin
            bad++;
            $display("FAIL holdoff_c%0d ready_i got=%b want=%b", i, ready_i, (i == 2));
         end
         step();
      end
      flow_done = 1'b1;
      step();
      flow_done = 1'b0;
      total++;
      if (ready_i !== 1'b1) begin
         bad++;
         $display("FAIL flow_done_ignored ready_i got=%b want=1", ready_i);
      end
      present(7'b0110011, 7'b1100011, 2'b11, 1'b1, "add_beq");
      valid_i = 2'b00;
      total++;
      if (ready_i !== 1'b0) begin
         bad++;
         $display("FAIL lane1_flow_wait ready_i got=%b want=0", ready_i);
      end
      flow_done = 1'b1;
      step();
      flow_done = 1'b0;
      step();
      step();
      total++;
      if (ready_i !== 1'b1) begin
         bad++;
         $display("FAIL lane1_flow_release ready_i got=%b want=1", ready_i);
      end
   endtask

   task automatic test_jump();
      present(7'b1101111, 7'b0010011, 2'b11, 1'b1, "jal");
      valid_i = 2'b00;
      for (int i = 0; i < 2; i++) begin
         total++;
         if (ready_i !== 1'b0) begin
            bad++;
            $display("FAIL jal_wait%0d ready_i got=%b want=0", i, ready_i);
         end
         step();
      end
      jump = 1'b1;
      #1;
      total++;
      if (ready_i !== 1'b0) begin
         bad++;
         $display("FAIL jump_cycle ready_i got=%b want=0", ready_i);
      end
      step();
      jump = 1'b0;
      total++;
      if (valid_o !== 2'b00) begin
         bad++;
         $display("FAIL jump_valid got=%b want=00", valid_o);
      end
      present(7'b0010011, 7'b0110011, 2'b11, 1'b0, "hold_block");
      valid_i = 2'b00;
      total++;
      if (ready_i !== 1'b0) begin
         bad++;
         $display("FAIL hold_last ready_i got=%b want=0", ready_i);
      end
      step();
      total++;
      if (ready_i !== 1'b1) begin
         bad++;
         $display("FAIL hold_release ready_i got=%b want=1", ready_i);
      end
   endtask

   task automatic test_backpressure();
      ready_o = 1'b0;
      present(7'b0010011, 7'b0110011, 2'b11, 1'b1, "bp_first");
      for (int c = 0; c < 4; c++) begin
         total++;
         if (valid_o !== last_exp.valid || instr_o !== last_exp.lanes) begin
            bad++;
            $display("FAIL bp_stable%0d got=%b/%h want=%b/%h", c, valid_o, instr_o,
                     last_exp.valid, last_exp.lanes);
         end
         present(7'b0110111, 7'b0010111, 2'b11, 1'b0, "bp_stall");
      end
      ready_o = 1'b1;
      present(7'b0110111, 7'b0010111, 2'b11, 1'b1, "bp_release");
      valid_i = 2'b00;
      step();
   endtask

   task automatic test_jump_busy();
      ready_o = 1'b0;
      present(7'b0110011, 7'b0100011, 2'b11, 1'b1, "jb_first");
      jump    = 1'b1;
      valid_i = 2'b11;
      #1;
      total++;
      if (ready_i !== 1'b0 || accept_o !== 2'd0) begin
         bad++;
         $display("FAIL jb_cycle ready/accept got=%b/%0d want=0/0", ready_i, accept_o);
      end
      step();
      jump    = 1'b0;
      valid_i = 2'b00;
      total++;
      if (valid_o !== 2'b00) begin
         bad++;
         $display("FAIL jb_flush valid_o got=%b want=00", valid_o);
      end
      total++;
      if (ready_i !== 1'b0) begin
         bad++;
         $display("FAIL jb_hold ready_i got=%b want=0", ready_i);
      end
      step();
      step();
      ready_o = 1'b1;
      #1;
      total++;
      if (ready_i !== 1'b1) begin
         bad++;
         $display("FAIL jb_release ready_i got=%b want=1", ready_i);
      end
   endtask

   task automatic test_unknown_reset();
      present(7'b1111111, 7'b0010011, 2'b11, 1'b1, "unknown_op");
      valid_i = 2'b00;
      total++;
      if (ready_i !== 1'b1) begin
         bad++;
         $display("FAIL unknown_no_wait ready_i got=%b want=1", ready_i);
      end
      present(7'b1100111, 7'b0110011, 2'b11, 1'b1, "jalr");
      valid_i = 2'b00;
      total++;
      if (ready_i !== 1'b0) begin
         bad++;
         $display("FAIL jalr_wait ready_i got=%b want=0", ready_i);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      total++;
      if (valid_o !== 2'b00) begin
         bad++;
         $display("FAIL midreset valid_o got=%b want=00", valid_o);
      end
      total++;
      if (ready_i !== 1'b1) begin
         bad++;
         $display("FAIL midreset ready_i got=%b want=1", ready_i);
      end
   endtask

   initial begin
      reset     = 1'b1;
      jump      = 1'b0;
      flow_done = 1'b0;
      ready_o   = 1'b1;
      valid_i   = '0;
      instr_i   = '0;
      #1;
      test_reset();
      test_alu_load();
      test_flow_holdoff();
      test_jump();
      test_backpressure();
      test_jump_busy();
      test_unknown_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
